// File: rtl/sram_if.sv
// Request/response bus between the memory-bus controller and a responder.
// Signal names follow the bus naming used by mem_controller.
interface sram_if;
    logic        HSEL;
    logic        HTRANS;
    logic [63:0] HADDR;
    logic        HWRITE;
    logic [1:0]  HSIZE;
    logic [63:0] HWDATA;
    logic [63:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    modport master (
        output HSEL, HTRANS, HADDR, HWRITE, HSIZE, HWDATA,
        input  HRDATA, HREADY, HRESP
    );

    modport slave (
        input  HSEL, HTRANS, HADDR, HWRITE, HSIZE, HWDATA,
        output HRDATA, HREADY, HRESP
    );
endinterface

// File: rtl/sram_responder.sv
// Memory-bus responder: windowed 64-bit-wide RAM with byte-lane writes,
// programmable wait states, HREADY stalls and a two-cycle error response.
module sram_responder #(
    parameter logic [63:0] ADDR_BASE   = 64'h0000_0000_8000_0000,
    parameter int          DEPTH_WORDS = 512,
    parameter int          WAIT_STATES = 1
) (
    input logic   CLK,
    input logic   RESET,
    sram_if.slave bus
);
    localparam int          AW   = $clog2(DEPTH_WORDS);
    localparam logic [63:0] SPAN = 64'(DEPTH_WORDS) * 64'd8;

    typedef enum logic [2:0] {IDLE, WAIT, RESP, ERR1, ERR2} state_t;

    state_t        state, state_nx;
    logic [3:0]    cnt, cnt_nx;
    logic [63:0]   rdata;
    logic [63:0]   mem [DEPTH_WORDS];

    logic [AW+2:0] off_q;
    logic          wr_q;
    logic [1:0]    size_q;
    logic [63:0]   wdata_q;

    logic          accept, err, commit, direct;
    logic [63:0]   off;
    logic [2:0]    amask;
    logic [AW+2:0] c_off;
    logic          c_wr;
    logic [1:0]    c_size;
    logic [63:0]   c_wdata;
    logic [2:0]    lane;
    logic [AW-1:0] idx;
    logic [7:0]    be;
    logic [63:0]   wd_sh, rd_mask, rd_word;

    assign bus.HREADY = (state == IDLE) || (state == RESP) || (state == ERR2);
    assign bus.HRESP  = (state == ERR1) || (state == ERR2);
    assign bus.HRDATA = rdata;

    assign accept = bus.HREADY & bus.HSEL & bus.HTRANS;
    assign off    = bus.HADDR - ADDR_BASE;
    assign amask  = 3'((4'd1 << bus.HSIZE) - 4'd1);
    assign err    = (bus.HADDR < ADDR_BASE) || (off >= SPAN) ||
                    ((bus.HADDR[2:0] & amask) != 3'd0);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            WAIT: begin
                if (cnt == 4'd0) state_nx = RESP;
                else             cnt_nx   = cnt - 4'd1;
            end
            ERR1: state_nx = ERR2;
            default: begin
                state_nx = IDLE;
                if (accept) begin
                    if (err) begin
                        state_nx = ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_nx = WAIT;
                        cnt_nx   = 4'(WAIT_STATES - 1);
                    end else begin
                        state_nx = RESP;
                    end
                end
            end
        endcase
    end

    // Zero-wait transfers commit on the accept edge itself, so take the live
    // bus fields; otherwise the transfer was latched when it was accepted.
    assign direct  = (state != WAIT);
    assign c_off   = direct ? off[AW+2:0]  : off_q;
    assign c_wr    = direct ? bus.HWRITE   : wr_q;
    assign c_size  = direct ? bus.HSIZE    : size_q;
    assign c_wdata = direct ? bus.HWDATA   : wdata_q;
    assign lane    = c_off[2:0];
    assign idx     = c_off[AW+2:3];
    assign commit  = RESET && (state_nx == RESP);

    assign be      = 8'((16'd1 << (5'd1 << c_size)) - 16'd1) << lane;
    assign wd_sh   = c_wdata << {lane, 3'b000};
    assign rd_mask = (c_size == 2'd3) ? '1 : ((64'd1 << (7'd8 << c_size)) - 64'd1);
    assign rd_word = (mem[idx] >> {lane, 3'b000}) & rd_mask;

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state <= IDLE;
            cnt   <= '0;
            rdata <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (commit && !c_wr) rdata <= rd_word;
        end
    end

    always_ff @(posedge CLK) begin
        if (accept) begin
            off_q   <= off[AW+2:0];
            wr_q    <= bus.HWRITE;
            size_q  <= bus.HSIZE;
            wdata_q <= bus.HWDATA;
        end
    end

    // RAM is never reset; a reset during WAIT suppresses the pending write.
    always_ff @(posedge CLK) begin
        if (commit && c_wr) begin
            for (int b = 0; b < 8; b++)
                if (be[b]) mem[idx][8*b +: 8] <= wd_sh[8*b +: 8];
        end
    end
endmodule

// File: tb/tb_sram_responder.sv
// Bench for sram_responder: one instance with one wait state, one with none,
// both checked against a byte-addressed memory model.
module tb_sram_responder;
    localparam logic [63:0] BASE  = 64'h0000_0000_8000_0000;
    localparam int          DEPTH = 512;
    localparam logic [63:0] SPAN  = 64'(DEPTH) * 64'd8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   passes = 0;
    int   fails = 0;

    logic [7:0]  mb [longint];
    logic [63:0] last_rd [2];

    sram_if b1 ();
    sram_if b0 ();

    sram_responder #(.ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(1))
        u_ws1 (.CLK(clk), .RESET(rst_n), .bus(b1));
    sram_responder #(.ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH), .WAIT_STATES(0))
        u_ws0 (.CLK(clk), .RESET(rst_n), .bus(b0));

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic get_rdy(int d);
        return (d == 1) ? b1.HREADY : b0.HREADY;
    endfunction
    function automatic logic get_resp(int d);
        return (d == 1) ? b1.HRESP : b0.HRESP;
    endfunction
    function automatic logic [63:0] get_rd(int d);
        return (d == 1) ? b1.HRDATA : b0.HRDATA;
    endfunction

    task automatic set_req(int d, bit v, bit wr, logic [1:0] sz, logic [63:0] a, logic [63:0] wd);
        if (d == 1) begin
            b1.HSEL = v; b1.HTRANS = v; b1.HWRITE = wr; b1.HSIZE = sz; b1.HADDR = a; b1.HWDATA = wd;
        end else begin
            b0.HSEL = v; b0.HTRANS = v; b0.HWRITE = wr; b0.HSIZE = sz; b0.HADDR = a; b0.HWDATA = wd;
        end
    endtask

    // Model: flat byte memory, transfer legality from the address rules.
    function automatic bit m_err(logic [63:0] a, logic [1:0] sz);
        return (a < BASE) || (a - BASE >= SPAN) || ((a % (64'd1 << sz)) != 64'd0);
    endfunction
    function automatic longint key(int d, logic [63:0] a);
        return (longint'(d) << 32) + longint'(a - BASE);
    endfunction
    task automatic m_write(int d, logic [63:0] a, logic [1:0] sz, logic [63:0] wd);
        for (int i = 0; i < (1 << sz); i++) mb[key(d, a) + longint'(i)] = wd[8*i +: 8];
    endtask
    function automatic logic [63:0] m_read(int d, logic [63:0] a, logic [1:0] sz);
        logic [63:0] v = '0;
        for (int i = 0; i < (1 << sz); i++) v |= 64'(mb[key(d, a) + longint'(i)]) << (8 * i);
        return v;
    endfunction

    // One isolated transfer: accept, then step through wait/error cycles.
    task automatic xfer(int d, bit wr, logic [1:0] sz, logic [63:0] a, logic [63:0] wd, string tag);
        bit e;
        e = m_err(a, sz);
        @(negedge clk); set_req(d, 1'b1, wr, sz, a, wd);
        @(negedge clk); set_req(d, 1'b0, 1'b0, 2'd0, 64'd0, 64'd0);
        if (e) begin
            chk({tag, ".err1_rdy"}, 64'(get_rdy(d)), 64'd0);
            chk({tag, ".err1_resp"}, 64'(get_resp(d)), 64'd1);
            @(negedge clk);
            chk({tag, ".err2_rdy"}, 64'(get_rdy(d)), 64'd1);
            chk({tag, ".err2_resp"}, 64'(get_resp(d)), 64'd1);
        end else begin
            for (int i = 0; i < d; i++) begin
                chk({tag, ".wait_rdy"}, 64'(get_rdy(d)), 64'd0);
                chk({tag, ".wait_resp"}, 64'(get_resp(d)), 64'd0);
                @(negedge clk);
            end
            chk({tag, ".resp_rdy"}, 64'(get_rdy(d)), 64'd1);
            chk({tag, ".resp_resp"}, 64'(get_resp(d)), 64'd0);
            if (wr) m_write(d, a, sz, wd);
            else    last_rd[d] = m_read(d, a, sz);
        end
        chk({tag, ".rdata"}, get_rd(d), last_rd[d]);
    endtask

    initial begin
        logic [63:0] a, wd;
        logic [1:0]  sz;
        int          r;

        set_req(1, 1'b0, 1'b0, 2'd0, 64'd0, 64'd0);
        set_req(0, 1'b0, 1'b0, 2'd0, 64'd0, 64'd0);
        last_rd[0] = '0;
        last_rd[1] = '0;

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int d = 0; d < 2; d++) begin
            chk("reset.rdy", 64'(get_rdy(d)), 64'd1);
            chk("reset.resp", 64'(get_resp(d)), 64'd0);
            chk("reset.rdata", get_rd(d), 64'd0);
        end

        xfer(1, 1'b1, 2'd3, BASE + 8, 64'h1122334455667788, "wr_dw");
        xfer(1, 1'b0, 2'd3, BASE + 8, 64'd0, "rd_dw");
        chk("rd_dw.const", get_rd(1), 64'h1122334455667788);

        xfer(1, 1'b1, 2'd0, BASE + 13, 64'hAB, "wr_b");
        xfer(1, 1'b0, 2'd3, BASE + 8, 64'd0, "rd_merge");
        chk("rd_merge.const", get_rd(1), 64'h1122_AB44_5566_7788);
        xfer(1, 1'b0, 2'd1, BASE + 12, 64'd0, "rd_half");
        chk("rd_half.const", get_rd(1), 64'h0000_0000_0000_AB44);

        xfer(1, 1'b0, 2'd3, BASE - 8, 64'd0, "err_below");
        xfer(1, 1'b0, 2'd3, BASE + SPAN, 64'd0, "err_above");
        xfer(1, 1'b0, 2'd1, BASE + 1, 64'd0, "err_align");
        xfer(1, 1'b1, 2'd3, BASE + SPAN, 64'hFFFF, "err_wr");
        xfer(1, 1'b0, 2'd3, BASE + 8, 64'd0, "rd_after_err");
        chk("rd_after_err.const", get_rd(1), 64'h1122_AB44_5566_7788);

        for (int w = 0; w < 16; w++)
            xfer(1, 1'b1, 2'd3, BASE + 64'(8 * w), {$urandom, $urandom}, "init");

        for (int n = 0; n < 40; n++) begin
            r  = int'($urandom_range(0, 9));
            sz = 2'($urandom_range(0, 3));
            if (r == 0)      a = BASE - 64'(8 * $urandom_range(1, 4));
            else if (r == 1) a = BASE + SPAN + 64'(8 * $urandom_range(0, 4));
            else             a = BASE + 64'(8 * $urandom_range(0, 15)) + 64'($urandom_range(0, 7));
            xfer(1, 1'($urandom_range(0, 1)), sz, a, {$urandom, $urandom}, "rand1");
        end

        // Zero wait states: back-to-back write then read of the same location.
        for (int n = 0; n < 20; n++) begin
            sz = (n == 0) ? 2'd3 : 2'($urandom_range(0, 3));
            a  = BASE + 64'(8 * $urandom_range(0, DEPTH - 1))
                      + (64'($urandom_range(0, 7)) & ~((64'd1 << sz) - 64'd1));
            wd = {$urandom, $urandom} & ((sz == 2'd3) ? '1 : ((64'd1 << (8 << sz)) - 64'd1));
            @(negedge clk); set_req(0, 1'b1, 1'b1, sz, a, wd);
            @(negedge clk);
            chk("b2b.wr_rdy", 64'(get_rdy(0)), 64'd1);
            m_write(0, a, sz, wd);
            set_req(0, 1'b1, 1'b0, sz, a, 64'd0);
            @(negedge clk);
            chk("b2b.rd_rdy", 64'(get_rdy(0)), 64'd1);
            chk("b2b.rd_resp", 64'(get_resp(0)), 64'd0);
            last_rd[0] = m_read(0, a, sz);
            chk("b2b.rdata", get_rd(0), last_rd[0]);
            if (n == 0) chk("b2b.rdata_wd", get_rd(0), wd);
            set_req(0, 1'b0, 1'b0, 2'd0, 64'd0, 64'd0);
        end

        // Reset while a write sits in WAIT: the write must be dropped.
        @(negedge clk); set_req(1, 1'b1, 1'b1, 2'd3, BASE + 8, 64'hDEAD);
        @(negedge clk); set_req(1, 1'b0, 1'b0, 2'd0, 64'd0, 64'd0);
        chk("rst_mid.wait_rdy", 64'(get_rdy(1)), 64'd0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        last_rd[0] = '0;
        last_rd[1] = '0;
        chk("rst_mid.rdy", 64'(get_rdy(1)), 64'd1);
        chk("rst_mid.resp", 64'(get_resp(1)), 64'd0);
        chk("rst_mid.rdata", get_rd(1), 64'd0);
        xfer(1, 1'b0, 2'd3, BASE + 8, 64'd0, "rst_mid.rd");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
